// File: rtl/bg_pkg.sv
// Shared constants and the VGA timing bundle for the background ROM draw stage.
package bg_pkg;

  localparam int BG_WIDTH  = 1024;
  localparam int BG_HEIGHT = 768;
  localparam int BG_ADDR_W = 20;
  localparam int RGB_W     = 12;
  localparam int CNT_W     = 11;
  localparam int X_W       = 10;

  localparam logic [RGB_W-1:0] BLANK_RGB = 12'h000;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
  } vga_tim_t;

endpackage

// File: rtl/bg_delay_line.sv
// Fixed-depth shift register used to hold timing while the ROM read is in flight.
module bg_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/draw_bg_rom.sv
// Background ROM stage: maps VGA timing to ROM addresses and re-aligns returned pixels.
// Define BG_SCROLL_EN to add a per-frame horizontal scroll offset.
module draw_bg_rom
  import bg_pkg::*;
#(
  parameter int ROM_LATENCY = 1
`ifdef BG_SCROLL_EN
  , parameter int SCROLL_STEP = 1
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_W-1:0]     hcount_in,
  input  logic                 hsync_in,
  input  logic                 hblnk_in,
  input  logic [CNT_W-1:0]     vcount_in,
  input  logic                 vsync_in,
  input  logic                 vblnk_in,
  output logic [BG_ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]     rom_rgb,
  output logic [CNT_W-1:0]     hcount_out,
  output logic                 hsync_out,
  output logic                 hblnk_out,
  output logic [CNT_W-1:0]     vcount_out,
  output logic                 vsync_out,
  output logic                 vblnk_out,
  output logic [RGB_W-1:0]     rgb_out
);

  localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(BG_WIDTH);
  localparam logic [CNT_W-1:0] V_LIMIT = CNT_W'(BG_HEIGHT);
  localparam logic [X_W-1:0]   X_MASK  = X_W'(BG_WIDTH - 1);
  localparam int               LINE_W  = $bits(vga_tim_t) + 1;

  vga_tim_t          tim_in;
  vga_tim_t          tim_a;
  vga_tim_t          tim_w;
  logic              vis;
  logic              valid_a;
  logic              valid_w;
  logic [X_W-1:0]    x_off;
  logic [X_W-1:0]    x_pix;
  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] line_q;

  assign tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                    vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

`ifdef BG_SCROLL_EN
  logic vsync_q;

  // Offset only moves on a vsync rising edge, which always falls inside vblank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      x_off   <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_in && !vsync_q) begin
        x_off <= (x_off + X_W'(SCROLL_STEP)) & X_MASK;
      end
    end
  end
`else
  assign x_off = '0;
`endif

  // Full 11-bit compares so hcount/vcount beyond the image never alias into it.
  always_comb begin
    vis = !hblnk_in && !vblnk_in && (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT);
    x_pix = (hcount_in[X_W-1:0] + x_off) & X_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      valid_a  <= 1'b0;
      tim_a    <= '0;
    end else begin
      rom_addr <= vis ? {vcount_in[9:0], x_pix} : '0;
      valid_a  <= vis;
      tim_a    <= tim_in;
    end
  end

  assign line_d = {valid_a, tim_a};

  bg_delay_line #(
    .DEPTH (ROM_LATENCY),
    .WIDTH (LINE_W)
  ) u_rom_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_d),
    .q     (line_q)
  );

  assign {valid_w, tim_w} = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out    <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      rgb_out    <= valid_w ? rom_rgb : BLANK_RGB;
      hcount_out <= tim_w.hcount;
      hsync_out  <= tim_w.hsync;
      hblnk_out  <= tim_w.hblnk;
      vcount_out <= tim_w.vcount;
      vsync_out  <= tim_w.vsync;
      vblnk_out  <= tim_w.vblnk;
    end
  end

endmodule

// File: tb/tb_draw_bg_rom.sv
// Bench for draw_bg_rom: two instances (ROM latency 1 and 3) share one stimulus stream.
`timescale 1ns/1ps
module tb_draw_bg_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;

  logic [19:0] addr1, addr3;
  logic [11:0] rom1, rom3;
  logic [10:0] hc1, vc1, hc3, vc3;
  logic        hs1, hb1, vs1, vb1, hs3, hb3, vs3, vb3;
  logic [11:0] rgb1, rgb3;

  draw_bg_rom #(
    .ROM_LATENCY (1)
`ifdef BG_SCROLL_EN
    , .SCROLL_STEP (4)
`endif
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n),
    .hcount_in (hcount_in), .hsync_in (hsync_in), .hblnk_in (hblnk_in),
    .vcount_in (vcount_in), .vsync_in (vsync_in), .vblnk_in (vblnk_in),
    .rom_addr (addr1), .rom_rgb (rom1),
    .hcount_out (hc1), .hsync_out (hs1), .hblnk_out (hb1),
    .vcount_out (vc1), .vsync_out (vs1), .vblnk_out (vb1),
    .rgb_out (rgb1)
  );

  draw_bg_rom #(
    .ROM_LATENCY (3)
`ifdef BG_SCROLL_EN
    , .SCROLL_STEP (4)
`endif
  ) u_dut3 (
    .clk (clk), .rst_n (rst_n),
    .hcount_in (hcount_in), .hsync_in (hsync_in), .hblnk_in (hblnk_in),
    .vcount_in (vcount_in), .vsync_in (vsync_in), .vblnk_in (vblnk_in),
    .rom_addr (addr3), .rom_rgb (rom3),
    .hcount_out (hc3), .hsync_out (hs3), .hblnk_out (hb3),
    .vcount_out (vc3), .vsync_out (vs3), .vblnk_out (vb3),
    .rgb_out (rgb3)
  );

  // ROM models return the low 12 address bits as the pixel.
  logic [11:0] rom3_pipe [3];
  always @(posedge clk) begin
    rom1         <= addr1[11:0];
    rom3_pipe[0] <= addr3[11:0];
    rom3_pipe[1] <= rom3_pipe[0];
    rom3_pipe[2] <= rom3_pipe[1];
  end
  assign rom3 = rom3_pipe[2];

  typedef struct packed {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic [19:0] addr;
    logic [11:0] rgb;
  } exp_t;

  exp_t hist[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   run1 = 0, run3 = 0;
  logic meas_width = 1'b0;
`ifdef BG_SCROLL_EN
  logic [9:0] m_xoff = '0;
  logic       m_vs_q = 1'b0;
`endif

  function automatic exp_t mk(input logic [10:0] h, input logic hs, input logic hb,
                              input logic [10:0] v, input logic vs, input logic vb,
                              input logic [19:0] addr, input logic [11:0] rgb);
    exp_t e;
    e.h = h; e.hs = hs; e.hb = hb; e.v = v; e.vs = vs; e.vb = vb;
    e.addr = addr; e.rgb = rgb;
    return e;
  endfunction

  function automatic exp_t model(input logic [9:0] xoff);
    logic       vis;
    logic [9:0] x;
    vis = !hblnk_in && !vblnk_in && (hcount_in < 11'd1024) && (vcount_in < 11'd768);
    x   = hcount_in[9:0] + xoff;
    return mk(hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
              vis ? {vcount_in[9:0], x} : 20'd0,
              vis ? {vcount_in[1:0], x} : 12'd0);
  endfunction

  function automatic logic [37:0] exp_out(input exp_t e);
    return {e.h, e.hs, e.hb, e.v, e.vs, e.vb, e.rgb};
  endfunction

  function automatic logic [37:0] out1();
    return {hc1, hs1, hb1, vc1, vs1, vb1, rgb1};
  endfunction

  function automatic logic [37:0] out3();
    return {hc3, hs3, hb3, vc3, vs3, vb3, rgb3};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic hs, input logic hb,
                       input logic [10:0] v, input logic vs, input logic vb);
    hcount_in = h; hsync_in = hs; hblnk_in = hb;
    vcount_in = v; vsync_in = vs; vblnk_in = vb;
  endtask

  task automatic drive_idle();
    drive(11'd1100, 1'b0, 1'b1, 11'd800, 1'b0, 1'b1);
  endtask

  // One clock: record sampled inputs in the model, then compare both DUTs against it.
  task automatic tick();
    exp_t e;
    exp_t z;
    @(posedge clk);
    if (rst_n) begin
`ifdef BG_SCROLL_EN
      hist.push_front(model(m_xoff));
      if (vsync_in && !m_vs_q) m_xoff = m_xoff + 10'd4;
      m_vs_q = vsync_in;
`else
      hist.push_front(model(10'd0));
`endif
      if (hist.size() > 8) void'(hist.pop_back());
    end
    #1;
    z = '0;
    e = (hist.size() >= 1) ? hist[0] : z;
    check("stream_rom_addr_l1", 64'(addr1), 64'(e.addr));
    check("stream_rom_addr_l3", 64'(addr3), 64'(e.addr));
    e = (hist.size() >= 3) ? hist[2] : z;
    check("stream_out_l1", 64'(out1()), 64'(exp_out(e)));
    e = (hist.size() >= 5) ? hist[4] : z;
    check("stream_out_l3", 64'(out3()), 64'(exp_out(e)));
    if (hs1) run1++;
    else begin
      if (meas_width && run1 > 0) check("hsync_width_l1", 64'(run1), 64'd136);
      run1 = 0;
    end
    if (hs3) run3++;
    else begin
      if (meas_width && run3 > 0) check("hsync_width_l3", 64'(run3), 64'd136);
      run3 = 0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    hist.delete();
`ifdef BG_SCROLL_EN
    m_xoff = '0;
    m_vs_q = 1'b0;
`endif
    check("reset_out_l1", 64'(out1()), 64'd0);
    check("reset_out_l3", 64'(out3()), 64'd0);
    check("reset_rom_addr", 64'({addr1, addr3}), 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_hold_l1", 64'(out1()), 64'd0);
    check("reset_hold_l3", 64'(out3()), 64'd0);
    rst_n = 1'b1;
  endtask

  localparam int NV = 12;
  exp_t vecs [NV];
  int   lines [11] = '{0, 1, 2, 766, 767, 768, 771, 772, 776, 777, 805};

  initial begin
    vecs[0]  = mk(11'd0,    1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[1]  = mk(11'd1023, 1'b0, 1'b0, 11'd767,  1'b0, 1'b0, 20'hBFFFF, 12'hFFF);
    vecs[2]  = mk(11'd1030, 1'b0, 1'b1, 11'd10,   1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[3]  = mk(11'd1030, 1'b0, 1'b0, 11'd10,   1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[4]  = mk(11'd500,  1'b0, 1'b1, 11'd10,   1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[5]  = mk(11'd5,    1'b0, 1'b0, 11'd768,  1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[6]  = mk(11'd5,    1'b0, 1'b0, 11'd1029, 1'b0, 1'b0, 20'h00000, 12'h000);
    vecs[7]  = mk(11'd683,  1'b0, 1'b0, 11'd341,  1'b0, 1'b0, 20'h556AB, 12'h6AB);
    vecs[8]  = mk(11'd100,  1'b0, 1'b0, 11'd2,    1'b0, 1'b1, 20'h00000, 12'h000);
    vecs[9]  = mk(11'd1023, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 20'h003FF, 12'h3FF);
    vecs[10] = mk(11'd0,    1'b0, 1'b0, 11'd767,  1'b0, 1'b0, 20'hBFC00, 12'hC00);
    vecs[11] = mk(11'd512,  1'b1, 1'b0, 11'd513,  1'b1, 1'b0, 20'h80600, 12'h600);

    drive_idle();
    rst_n = 1'b1;
    #2;
    do_reset(3);

    // Directed vectors, one per clock, with exact per-instance latency.
    for (int i = 0; i < NV + 4; i++) begin
      if (i < NV) drive(vecs[i].h, vecs[i].hs, vecs[i].hb, vecs[i].v, vecs[i].vs, vecs[i].vb);
      else drive_idle();
      tick();
      if (i < NV) check("tbl_rom_addr", 64'(addr1), 64'(vecs[i].addr));
      if (i >= 2 && i - 2 < NV) check("tbl_out_l1", 64'(out1()), 64'(exp_out(vecs[i-2])));
      if (i >= 4 && i - 4 < NV) check("tbl_out_l3", 64'(out3()), 64'(exp_out(vecs[i-4])));
    end

    // Frame lines covering top, bottom, blanking and vsync regions.
    repeat (6) tick();
    meas_width = 1'b1;
    foreach (lines[li]) begin
      for (int h = 0; h < 1344; h++) begin
        drive(11'(h), (h >= 1048 && h < 1184), (h >= 1024),
              11'(lines[li]), (lines[li] >= 771 && lines[li] < 777), (lines[li] >= 768));
        tick();
      end
    end
    meas_width = 1'b0;
    drive_idle();
    repeat (6) tick();

    // Reset mid-line at hcount 400, then resume and look for the first pixel.
    for (int h = 380; h <= 400; h++) begin
      drive(11'(h), 1'b0, 1'b0, 11'd5, 1'b0, 1'b0);
      tick();
    end
    do_reset(2);
    for (int k = 1; k <= 6; k++) begin
      drive(11'(401 + k), 1'b0, 1'b0, 11'd5, 1'b0, 1'b0);
      tick();
      check("rst_resume_l1", 64'(rgb1), (k >= 3) ? 64'(12'h592 + 12'(k - 3)) : 64'd0);
      check("rst_resume_l3", 64'(rgb3), (k >= 5) ? 64'(12'h592 + 12'(k - 5)) : 64'd0);
    end
    drive_idle();
    repeat (6) tick();

`ifdef BG_SCROLL_EN
    do_reset(2);
    drive(11'd1100, 1'b0, 1'b1, 11'd780, 1'b1, 1'b1); tick(); tick();
    drive(11'd1100, 1'b0, 1'b1, 11'd780, 1'b0, 1'b1); tick();
    drive(11'd1022, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0);   tick();
    check("scroll_frame1_addr", 64'(addr1), 64'h00002);
    for (int f = 0; f < 255; f++) begin
      drive(11'd1100, 1'b0, 1'b1, 11'd780, 1'b1, 1'b1); tick();
      drive(11'd1100, 1'b0, 1'b1, 11'd780, 1'b0, 1'b1); tick();
    end
    drive(11'd1022, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0); tick();
    check("scroll_wrap_addr", 64'(addr1), 64'h003FE);
    drive_idle();
    repeat (6) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
